// File: rtl/fas_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor and its 1-bit cell.
package fas_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fas_state_t;

    localparam logic FAS_ADD = 1'b0;
    localparam logic FAS_SUB = 1'b1;

    // Bit-counter width: $clog2(w), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/fas.sv
// Combinational 1-bit full adder/subtractor cell: a_ns = 0 adds, a_ns = 1 subtracts.
module fas
    import fas_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic a_ns,
    output logic s,
    output logic cout
);

    always_comb begin
        s = a ^ b ^ cin;
        if (a_ns == FAS_SUB) begin
            cout = (~a & b) | (~a & cin) | (b & cin);
        end else begin
            cout = (a & b) | (a & cin) | (b & cin);
        end
    end

endmodule

// File: rtl/fas_serial.sv
// W-bit LSB-first serial adder/subtractor built around one fas cell.
// Optional macro FAS_SERIAL_OVF_EN enables the signed-overflow output.
module fas_serial
    import fas_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         a_ns,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         ovf
);

    localparam int unsigned CW = cnt_width(W);

    fas_state_t    state_q, state_d;
    logic [W-1:0]  a_sh_q, a_sh_d;
    logic [W-1:0]  b_sh_q, b_sh_d;
    logic [W-1:0]  res_sh_q, res_sh_d;
    logic [W-1:0]  s_q, s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          op_q, op_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;

    logic          bit_s;
    logic          bit_c;
    logic          accept;
    logic          last;
    logic [W-1:0]  res_next;

    fas u_fas (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .a_ns (op_q),
        .s    (bit_s),
        .cout (bit_c)
    );

    // Result bits enter at the MSB so the word is aligned after W shifts.
    assign res_next = W'({bit_s, res_sh_q} >> 1);

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        accept   = 1'b0;
        last     = 1'b0;

        case (state_q)
            IDLE: begin
                accept = start;
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_next;
                carry_d  = bit_c;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    last    = 1'b1;
                    state_d = DONE;
                    s_d     = res_next;
                    cout_d  = bit_c;
                end
            end
            DONE: begin
                accept  = start;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d  = RUN;
            a_sh_d   = a;
            b_sh_d   = b;
            op_d     = a_ns;
            carry_d  = cin;
            cnt_d    = '0;
            res_sh_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
        end
    end

`ifdef FAS_SERIAL_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;

    // The final serial bit is the result MSB.
    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
        if (last) begin
            if (op_q == FAS_ADD) begin
                ovf_d = (a_msb_q == b_msb_q) && (bit_s != a_msb_q);
            end else begin
                ovf_d = (a_msb_q != b_msb_q) && (bit_s != a_msb_q);
            end
        end
        if (accept) begin
            a_msb_d = a[W-1];
            b_msb_d = b[W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_fas_serial.sv
// Directed scoreboard bench for fas_serial at W=8 and W=1.
module tb_fas_serial;

    typedef struct packed {
        logic [7:0] s;
        logic       cout;
        logic       ovf;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0, cin8 = 1'b0, ans8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] s8;

    logic       start1 = 1'b0, cin1 = 1'b0, ans1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1, ovf1;
    logic [0:0] s1;

    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt8 = 0;
    res_t q8[$];
    res_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) if (done8 === 1'b1) done_cnt8 <= done_cnt8 + 1;

    fas_serial #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .a_ns(ans8),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
    );

    fas_serial #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1), .a_ns(ans1),
        .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1)
    );

    function automatic res_t model(input int w, input int a, input int b, input int c, input int sub);
        res_t r;
        int mask, full, sa, sb, sr, half;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        if (sub != 0) begin
            full   = a - b - c;
            r.cout = (a < b + c);
        end else begin
            full   = a + b + c;
            r.cout = ((full >> w) & 1) != 0;
        end
        r.s = 8'(full & mask);
        sa  = (a >= half) ? a - (1 << w) : a;
        sb  = (b >= half) ? b - (1 << w) : b;
        sr  = (sub != 0) ? sa - sb - c : sa + sb + c;
`ifdef FAS_SERIAL_OVF_EN
        r.ovf = (sr > half - 1) || (sr < -half);
`else
        r.ovf = 1'b0;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop8(input string tag);
        res_t e;
        chk({tag, "_sb_nonempty"}, 32'(q8.size() != 0), 32'd1);
        if (q8.size() != 0) begin
            e = q8.pop_front();
            chk({tag, "_s"}, 32'(s8), 32'(e.s));
            chk({tag, "_cout"}, 32'(cout8), 32'(e.cout));
            chk({tag, "_ovf"}, 32'(ovf8), 32'(e.ovf));
        end
    endtask

    // Drive one operation on dut8; returns one edge later (cycle 1).
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sub);
        a8 = a; b8 = b; cin8 = c; ans8 = sub; start8 = 1'b1;
        q8.push_back(model(8, int'(a), int'(b), int'(c), int'(sub)));
        tick();
        start8 = 1'b0;
    endtask

    task automatic wait_done8(input int from_cyc, input int exp_cyc, input string tag);
        int cyc = from_cyc;
        while (done8 !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
        if (done8 === 1'b1) pop8(tag);
    endtask

    initial begin
        int d0;
        res_t e;

        tick(); tick();
        chk("rst_busy8", 32'(busy8), 0);
        chk("rst_done8", 32'(done8), 0);
        chk("rst_s8", 32'(s8), 0);
        chk("rst_cout8", 32'(cout8), 0);
        chk("rst_ovf8", 32'(ovf8), 0);
        chk("rst_busy1", 32'(busy1), 0);
        rst = 1'b0;
        tick();

        // Add with signed overflow; done only in cycle 9.
        issue8(8'h7F, 8'h01, 1'b0, 1'b0);
        chk("add1_busy", 32'(busy8), 1);
        wait_done8(1, 9, "add1");
        chk("add1_busy_done", 32'(busy8), 1);
        tick();
        chk("add1_done_clr", 32'(done8), 0);
        chk("add1_idle", 32'(busy8), 0);
        chk("add1_s_hold", 32'(s8), 32'h80);

        // Subtract with borrow; previous s must stay visible during RUN.
        issue8(8'h05, 8'h07, 1'b0, 1'b1);
        tick(); tick(); tick(); tick();
        chk("sub1_s_hold_run", 32'(s8), 32'h80);
        wait_done8(5, 9, "sub1");
        tick();
        issue8(8'h80, 8'h01, 1'b0, 1'b1);
        wait_done8(1, 9, "sub2");
        tick();

        // Start re-pulsed during RUN with a new a is ignored.
        d0 = done_cnt8;
        issue8(8'hFF, 8'h01, 1'b1, 1'b0);
        tick(); tick();
        a8 = 8'h00; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done8(4, 9, "add2");
        tick(); tick(); tick();
        chk("add2_one_done", 32'(done_cnt8 - d0), 1);
        chk("add2_idle", 32'(busy8), 0);

        // Back-to-back with start held high.
        a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b1; ans8 = 1'b0; start8 = 1'b1;
        q8.push_back(model(8, 'h3C, 'h5A, 1, 0));
        q8.push_back(model(8, 'h10, 'hC3, 0, 1));
        for (int cyc = 1; cyc <= 19; cyc++) begin
            tick();
            if (cyc == 1) begin
                a8 = 8'h10; b8 = 8'hC3; cin8 = 1'b0; ans8 = 1'b1;
            end
            if (cyc == 10) start8 = 1'b0;
            chk($sformatf("b2b_done_c%0d", cyc), 32'(done8), 32'(cyc == 9 || cyc == 18));
            if (done8 === 1'b1) pop8($sformatf("b2b_c%0d", cyc));
        end

        // Reset mid-run discards the operation.
        d0 = done_cnt8;
        issue8(8'h12, 8'h34, 1'b0, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", 32'(busy8), 0);
        chk("mrst_done", 32'(done8), 0);
        chk("mrst_s", 32'(s8), 0);
        chk("mrst_cout", 32'(cout8), 0);
        chk("mrst_ovf", 32'(ovf8), 0);
        if (q8.size() != 0) e = q8.pop_back();
        for (int i = 0; i < 12; i++) tick();
        chk("mrst_no_done", 32'(done_cnt8 - d0), 0);
        issue8(8'hA5, 8'h5B, 1'b1, 1'b1);
        wait_done8(1, 9, "post_rst");
        tick();

        // W = 1 exhaustive against cell arithmetic.
        for (int i = 0; i < 16; i++) begin
            a1 = i[0]; b1 = i[1]; cin1 = i[2]; ans1 = i[3]; start1 = 1'b1;
            q1.push_back(model(1, int'(i[0]), int'(i[1]), int'(i[2]), int'(i[3])));
            tick();
            start1 = 1'b0;
            chk($sformatf("w1_%0d_run_busy", i), 32'(busy1), 1);
            chk($sformatf("w1_%0d_run_done", i), 32'(done1), 0);
            tick();
            chk($sformatf("w1_%0d_done", i), 32'(done1), 1);
            if (done1 === 1'b1 && q1.size() != 0) begin
                e = q1.pop_front();
                chk($sformatf("w1_%0d_s", i), 32'(s1), 32'(e.s[0]));
                chk($sformatf("w1_%0d_cout", i), 32'(cout1), 32'(e.cout));
                chk($sformatf("w1_%0d_ovf", i), 32'(ovf1), 32'(e.ovf));
            end
            tick();
            chk($sformatf("w1_%0d_idle", i), 32'(busy1), 0);
        end

        chk("sb8_drained", 32'(q8.size()), 0);
        chk("sb1_drained", 32'(q1.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
